// File: rtl/imm_packer_pkg.sv
// Shared definitions for the immediate packer: format encodings, field placement
// constants, FSM state type and the upper-bit uniformity helper used by the range check.
package imm_pkg;

    localparam int IMM_W   = 64;
    localparam int FIELD_W = 26;

    typedef enum logic [1:0] {
        FMT_ALU = 2'b00,
        FMT_DT  = 2'b01,
        FMT_B   = 2'b10,
        FMT_CB  = 2'b11
    } imm_fmt_t;

    // Instruction bit positions occupied by each format's immediate.
    localparam int ALU_LSB  = 10;
    localparam int ALU_MSB  = 21;
    localparam int DT_LSB   = 12;
    localparam int DT_MSB   = 20;
    localparam int B_LSB    = 0;
    localparam int B_MSB    = 25;
    localparam int CB_LSB   = 5;
    localparam int CB_MSB   = 23;
    localparam int CB_SHIFT = 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] field;
        logic [1:0]         fmt;
        logic               err;
    } packed_beat_t;

    // True when v[IMM_W-1:lo] are all zeros or all ones, i.e. v sign-extends from bit lo.
    function automatic logic upper_uniform(input logic [IMM_W-1:0] v, input int lo);
        logic ones;
        logic zeros;
        ones  = 1'b1;
        zeros = 1'b1;
        for (int i = 0; i < IMM_W; i++) begin
            if (i >= lo) begin
                ones  = ones & v[i];
                zeros = zeros & ~v[i];
            end
        end
        return ones | zeros;
    endfunction

endpackage

// File: rtl/imm_packer_if.sv
// Upstream immediate stream and downstream packed-field stream of imm_packer.
// slave is the packer's view, master is the view of whatever drives and consumes it.
interface imm_packer_if;
    import imm_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [IMM_W-1:0]   in_imm;
    logic [1:0]         in_fmt;
    logic               out_valid;
    logic               out_ready;
    logic [FIELD_W-1:0] out_field;
    logic [1:0]         out_fmt;
    logic               out_err;

    modport master (
        output in_valid, in_imm, in_fmt, out_ready,
        input  in_ready, out_valid, out_field, out_fmt, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_fmt, out_ready,
        output in_ready, out_valid, out_field, out_fmt, out_err
    );

endinterface

// File: rtl/imm_field_pack.sv
// Combinational packing of a 64-bit immediate into its format's instruction bits,
// with the representability check; an unrepresentable immediate yields an all-zero field.
module imm_field_pack
    import imm_pkg::*;
(
    input  logic [IMM_W-1:0]   imm,
    input  logic [1:0]         fmt,
    output logic [FIELD_W-1:0] field,
    output logic               err
);

    logic [FIELD_W-1:0] raw;

    // ALU immediates are unsigned; the address formats are signed and must sign-extend
    // from their top kept bit. Conditional branches also drop two always-zero LSBs.
    always_comb begin
        raw = '0;
        err = 1'b0;
        case (imm_fmt_t'(fmt))
            FMT_ALU: begin
                raw[ALU_MSB:ALU_LSB] = imm[ALU_MSB-ALU_LSB:0];
                err = |imm[IMM_W-1:ALU_MSB-ALU_LSB+1];
            end
            FMT_DT: begin
                raw[DT_MSB:DT_LSB] = imm[DT_MSB-DT_LSB:0];
                err = !upper_uniform(imm, DT_MSB - DT_LSB);
            end
            FMT_B: begin
                raw[B_MSB:B_LSB] = imm[B_MSB-B_LSB:0];
                err = !upper_uniform(imm, B_MSB - B_LSB);
            end
            FMT_CB: begin
                raw[CB_MSB:CB_LSB] = imm[CB_MSB-CB_LSB+CB_SHIFT:CB_SHIFT];
                err = !upper_uniform(imm, CB_MSB - CB_LSB + CB_SHIFT)
                      || (imm[CB_SHIFT-1:0] != '0);
            end
            default: begin
                raw = '0;
                err = 1'b0;
            end
        endcase
    end

    always_comb begin
        field = err ? '0 : raw;
    end

endmodule

// File: rtl/imm_packer.sv
// Two-stage valid/ready immediate packer with sticky range-error reporting and optional halt.
// Define IMM_PACKER_ERRCNT_EN to add the saturating err_cnt output.
module imm_packer
    import imm_pkg::*;
#(
    parameter bit HALT_ON_ERR = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    imm_packer_if.slave bus,
    input  logic        err_clr,
    output logic        err_sticky
`ifdef IMM_PACKER_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    state_t             state;
    state_t             state_nxt;

    logic               s1_valid;
    logic [IMM_W-1:0]   s1_imm;
    logic [1:0]         s1_fmt;
    logic               s2_valid;
    packed_beat_t       s2_beat;

    logic [FIELD_W-1:0] pk_field;
    logic               pk_err;

    logic               s2_free;
    logic               s1_move;
    logic               s1_free;
    logic               in_fire;
    logic               new_err;

    // A stage may take new data when empty or when its occupant leaves this same cycle.
    assign s2_free = !s2_valid || bus.out_ready;
    assign s1_move = s1_valid && s2_free;
    assign s1_free = !s1_valid || s1_move;
    assign in_fire = bus.in_valid && bus.in_ready;
    assign new_err = s1_move && pk_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_imm   <= '0;
            s1_fmt   <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_imm   <= bus.in_imm;
            s1_fmt   <= bus.in_fmt;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    imm_field_pack u_pack (
        .imm   (s1_imm),
        .fmt   (s1_fmt),
        .field (pk_field),
        .err   (pk_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_beat  <= '0;
        end else if (s1_move) begin
            s2_valid      <= 1'b1;
            s2_beat.field <= pk_field;
            s2_beat.fmt   <= s1_fmt;
            s2_beat.err   <= pk_err;
        end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_field = s2_beat.field;
    assign bus.out_fmt   = s2_beat.fmt;
    assign bus.out_err   = s2_beat.err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A fresh error outranks a simultaneous clear so it can never be silently lost.
    always_comb begin
        state_nxt = state;
        if (new_err && HALT_ON_ERR) begin
            state_nxt = ST_HALT;
        end else if (err_clr) begin
            state_nxt = ST_RUN;
        end
    end

    always_comb begin
        bus.in_ready = s1_free && (state == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (new_err) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

`ifdef IMM_PACKER_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (new_err) begin
            if (err_clr) begin
                err_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end else if (err_clr) begin
            err_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Bench for imm_packer: directed checks on a halting instance, randomized traffic on a
// non-halting instance compared against an arithmetic reference model.
module tb_imm_packer;
    import imm_pkg::*;

    typedef struct {
        logic [25:0] field;
        logic [1:0]  fmt;
        logic        err;
    } exp_beat_t;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic h_clr    = 1'b0;
    logic f_clr    = 1'b0;
    logic h_sticky;
    logic f_sticky;
`ifdef IMM_PACKER_ERRCNT_EN
    logic [7:0] h_cnt;
    logic [1:0] f_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    imm_packer_if hbus();
    imm_packer_if fbus();

    imm_packer #(.HALT_ON_ERR(1'b1), .CNT_W(8)) dut_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (hbus),
        .err_clr    (h_clr),
        .err_sticky (h_sticky)
`ifdef IMM_PACKER_ERRCNT_EN
        ,
        .err_cnt    (h_cnt)
`endif
    );

    imm_packer #(.HALT_ON_ERR(1'b0), .CNT_W(2)) dut_f (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (fbus),
        .err_clr    (f_clr),
        .err_sticky (f_sticky)
`ifdef IMM_PACKER_ERRCNT_EN
        ,
        .err_cnt    (f_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: representable ranges and placement computed with plain arithmetic.
    function automatic void model_pack(input logic [63:0] imm, input logic [1:0] fmt,
                                       output logic [25:0] field, output logic err);
        longint      s;
        logic [63:0] f;
        s   = longint'(imm);
        f   = 64'd0;
        err = 1'b0;
        case (fmt)
            2'd0: begin
                err = (imm > 64'd4095);
                f   = (imm % 64'd4096) * 64'd1024;
            end
            2'd1: begin
                err = (s < -256) || (s > 255);
                f   = (imm % 64'd512) * 64'd4096;
            end
            2'd2: begin
                err = (s < -33554432) || (s > 33554431);
                f   = imm % 64'd67108864;
            end
            default: begin
                err = (s < -1048576) || (s > 1048575) || (imm % 64'd4 != 64'd0);
                f   = ((imm / 64'd4) % 64'd524288) * 64'd32;
            end
        endcase
        if (err) f = 64'd0;
        field = f[25:0];
    endfunction

    function automatic logic [63:0] rand_imm();
        int          ks[8] = '{8, 9, 11, 12, 19, 20, 25, 26};
        logic [63:0] p;
        logic [63:0] v;
        case ($urandom_range(0, 4))
            0: return 64'($urandom_range(0, 5000));
            1: return 64'd0 - 64'($urandom_range(1, 3000));
            2: return {$urandom, $urandom};
            3: begin
                p = 64'd1 << ks[$urandom_range(0, 7)];
                case ($urandom_range(0, 3))
                    0:       return p;
                    1:       return p - 64'd1;
                    2:       return 64'd0 - p;
                    default: return 64'd0 - p - 64'd1;
                endcase
            end
            default: begin
                v = 64'($urandom_range(0, 1200000)) * 64'd4 + 64'($urandom_range(0, 1) * 2);
                return ($urandom_range(0, 1) != 0) ? 64'd0 - v : v;
            end
        endcase
    endfunction

    task automatic applyStimulus(input logic [63:0] imm, input logic [1:0] fmt);
        logic ok;
        ok = 1'b0;
        hbus.in_valid = 1'b1;
        hbus.in_imm   = imm;
        hbus.in_fmt   = fmt;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = hbus.in_ready;
            @(posedge clk);
            #1;
        end
        hbus.in_valid = 1'b0;
        checkOutput("accept", 64'(ok), 64'd1);
    endtask

    task automatic checkBeat(input string tag, input logic [25:0] field,
                             input logic err, input logic [1:0] fmt);
        for (int n = 0; n < 8 && !hbus.out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_valid"}, 64'(hbus.out_valid), 64'd1);
        checkOutput({tag, "_field"}, 64'(hbus.out_field), 64'(field));
        checkOutput({tag, "_err"},   64'(hbus.out_err),   64'(err));
        checkOutput({tag, "_fmt"},   64'(hbus.out_fmt),   64'(fmt));
    endtask

    task automatic pulseHclr();
        h_clr = 1'b1;
        @(posedge clk);
        #1;
        h_clr = 1'b0;
    endtask

    task automatic pulseFclr();
        f_clr = 1'b1;
        @(posedge clk);
        #1;
        f_clr = 1'b0;
    endtask

    initial begin
        logic [63:0] burst [4];
        logic [25:0] burst_exp [4];
        logic [25:0] got_q [$];
        exp_beat_t   exp_q [$];
        exp_beat_t   e;
        int          k;
        int          stale;
        int          nerr;
        int          nacc;
        logic        fire;
        logic [25:0] mf;
        logic        me;

        burst     = '{64'd1, 64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
        burst_exp = '{26'h1, 26'h2, 26'h3, 26'h3FF_FFFF};

        hbus.in_valid = 1'b0; hbus.in_imm = '0; hbus.in_fmt = '0; hbus.out_ready = 1'b1;
        fbus.in_valid = 1'b0; fbus.in_imm = '0; fbus.in_fmt = '0; fbus.out_ready = 1'b1;

        #2;
        checkOutput("rst_out_valid", 64'(hbus.out_valid), 64'd0);
        checkOutput("rst_out_field", 64'(hbus.out_field), 64'd0);
        checkOutput("rst_out_fmt",   64'(hbus.out_fmt),   64'd0);
        checkOutput("rst_out_err",   64'(hbus.out_err),   64'd0);
        checkOutput("rst_sticky",    64'(h_sticky),       64'd0);
`ifdef IMM_PACKER_ERRCNT_EN
        checkOutput("rst_err_cnt",   64'(h_cnt),          64'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", 64'(hbus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed packing");
        applyStimulus(64'hABC, 2'b00);
        checkBeat("alu_abc", 26'h2AF000, 1'b0, 2'b00);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFF8, 2'b11);
        checkBeat("cb_neg8", 26'hFFFFC0, 1'b0, 2'b11);

        $display("[TB] halt on misaligned branch");
        applyStimulus(64'h6, 2'b11);
        checkBeat("cb_6", 26'h0, 1'b1, 2'b11);
        checkOutput("cb_6_sticky", 64'(h_sticky), 64'd1);
        checkOutput("cb_6_halt_ready", 64'(hbus.in_ready), 64'd0);
`ifdef IMM_PACKER_ERRCNT_EN
        checkOutput("cb_6_err_cnt", 64'(h_cnt), 64'd1);
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("halt_holds_ready", 64'(hbus.in_ready), 64'd0);
        checkOutput("halt_drained", 64'(hbus.out_valid), 64'd0);
        pulseHclr();
        checkOutput("clr_ready", 64'(hbus.in_ready), 64'd1);
        checkOutput("clr_sticky", 64'(h_sticky), 64'd0);

        $display("[TB] halt on data-transfer range error");
        applyStimulus(64'h100, 2'b01);
        checkBeat("dt_100", 26'h0, 1'b1, 2'b01);
        checkOutput("dt_100_sticky", 64'(h_sticky), 64'd1);
        checkOutput("dt_100_ready", 64'(hbus.in_ready), 64'd0);
        pulseHclr();
        checkOutput("dt_clr_ready", 64'(hbus.in_ready), 64'd1);

        $display("[TB] error coinciding with clear");
        applyStimulus(64'h1000, 2'b00);
        h_clr = 1'b1;
        @(posedge clk);
        #1;
        h_clr = 1'b0;
        checkOutput("coll_valid", 64'(hbus.out_valid), 64'd1);
        checkOutput("coll_err", 64'(hbus.out_err), 64'd1);
        checkOutput("coll_sticky", 64'(h_sticky), 64'd1);
        checkOutput("coll_ready", 64'(hbus.in_ready), 64'd0);
`ifdef IMM_PACKER_ERRCNT_EN
        checkOutput("coll_err_cnt", 64'(h_cnt), 64'd1);
`endif
        pulseHclr();
        checkOutput("coll_clr_ready", 64'(hbus.in_ready), 64'd1);

        $display("[TB] backpressure burst");
        hbus.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            hbus.in_valid = (k < 4);
            hbus.in_imm   = burst[k & 3];
            hbus.in_fmt   = 2'b10;
            @(negedge clk);
            fire = hbus.in_valid && hbus.in_ready;
            @(posedge clk);
            #1;
            if (fire) k++;
        end
        checkOutput("burst_accepted", 64'(k), 64'd2);
        checkOutput("burst_ready_low", 64'(hbus.in_ready), 64'd0);
        checkOutput("burst_head_held", 64'(hbus.out_field), 64'h1);
        hbus.out_ready = 1'b1;
        got_q.delete();
        for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
            hbus.in_valid = (k < 4);
            hbus.in_imm   = burst[k & 3];
            @(negedge clk);
            if (hbus.out_valid && hbus.out_ready) got_q.push_back(hbus.out_field);
            fire = hbus.in_valid && hbus.in_ready;
            @(posedge clk);
            #1;
            if (fire) k++;
        end
        hbus.in_valid = 1'b0;
        checkOutput("burst_count", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) checkOutput($sformatf("burst_%0d", i), 64'(got_q[i]), 64'(burst_exp[i]));
        end

        $display("[TB] reset with beats in flight");
        hbus.out_ready = 1'b0;
        applyStimulus(64'd5, 2'b10);
        applyStimulus(64'd7, 2'b10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(hbus.out_valid), 64'd0);
        checkOutput("midrst_field", 64'(hbus.out_field), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hbus.out_ready = 1'b1;
        #1;
        checkOutput("midrst_ready", 64'(hbus.in_ready), 64'd1);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (hbus.out_valid) stale++;
        end
        checkOutput("midrst_stale", 64'(stale), 64'd0);

        $display("[TB] randomized traffic, non-halting instance");
        nerr = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 700; cyc++) begin
            fbus.in_valid  = (cyc < 40) || ($urandom_range(0, 3) != 0);
            fbus.out_ready = (cyc < 40) || ($urandom_range(0, 3) != 0);
            fbus.in_imm    = rand_imm();
            fbus.in_fmt    = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (cyc > 2 && cyc < 40) checkOutput("stream_ready", 64'(fbus.in_ready), 64'd1);
            if (fbus.out_valid) begin
                checkOutput("rand_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    checkOutput("rand_field", 64'(fbus.out_field), 64'(e.field));
                    checkOutput("rand_fmt",   64'(fbus.out_fmt),   64'(e.fmt));
                    checkOutput("rand_err",   64'(fbus.out_err),   64'(e.err));
                    if (fbus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (fbus.in_valid && fbus.in_ready) begin
                model_pack(fbus.in_imm, fbus.in_fmt, mf, me);
                e.field = mf;
                e.fmt   = fbus.in_fmt;
                e.err   = me;
                exp_q.push_back(e);
                if (me) nerr++;
            end
            @(posedge clk);
            #1;
        end
        fbus.in_valid  = 1'b0;
        fbus.out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (fbus.out_valid) begin
                e = exp_q.pop_front();
                checkOutput("drain_field", 64'(fbus.out_field), 64'(e.field));
                checkOutput("drain_err",   64'(fbus.out_err),   64'(e.err));
            end
            @(posedge clk);
            #1;
        end
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
        checkOutput("rand_sticky", 64'(f_sticky), 64'(nerr > 0));
`ifdef IMM_PACKER_ERRCNT_EN
        checkOutput("rand_err_cnt", 64'(f_cnt), 64'((nerr > 3) ? 3 : nerr));
`endif
        pulseFclr();
        checkOutput("f_clr_sticky", 64'(f_sticky), 64'd0);

        $display("[TB] error counter saturation");
        nacc = 0;
        fbus.in_imm = 64'h1000;
        fbus.in_fmt = 2'b00;
        for (int c = 0; c < 20 && nacc < 5; c++) begin
            fbus.in_valid = 1'b1;
            @(negedge clk);
            fire = fbus.in_ready;
            @(posedge clk);
            #1;
            if (fire) nacc++;
        end
        fbus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("sat_accepted", 64'(nacc), 64'd5);
        checkOutput("sat_no_halt", 64'(fbus.in_ready), 64'd1);
        checkOutput("sat_sticky", 64'(f_sticky), 64'd1);
`ifdef IMM_PACKER_ERRCNT_EN
        checkOutput("sat_err_cnt", 64'(f_cnt), 64'd3);
`endif
        pulseFclr();
        checkOutput("sat_clr_sticky", 64'(f_sticky), 64'd0);
`ifdef IMM_PACKER_ERRCNT_EN
        checkOutput("sat_clr_cnt", 64'(f_cnt), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
